// File: rtl/regfile_pkg.sv
// Shared constants and state type for the register-file write-port scheduler.
package regfile_pkg;
  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned DATA_W    = 32;

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam logic [ADDR_W-1:0] R0_ADDR = 5'd0;

  typedef enum logic {
    STATE_INIT = ST_INIT,
    STATE_RUN  = ST_RUN
  } state_e;
endpackage

// File: rtl/wb_prio_arb.sv
// Two-requester write-port arbiter: MEM wins by default, ALU wins once it has
// been refused STARVE_LIMIT consecutive cycles.
module wb_prio_arb #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic alu_valid,
  input  logic mem_valid,
  output logic alu_ready,
  output logic mem_ready
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_r;
  logic       starve_hit_s;
  logic       alu_ready_s;
  logic       mem_ready_s;

  assign starve_hit_s = (starve_cnt_r >= LIMIT);

  // Ready generation; both stay low outside RUN.
  always_comb begin
    alu_ready_s = 1'b0;
    mem_ready_s = 1'b0;
    if (run) begin
      mem_ready_s = !(alu_valid && starve_hit_s);
      alu_ready_s = alu_valid && (!mem_valid || starve_hit_s);
    end else begin
      alu_ready_s = 1'b0;
      mem_ready_s = 1'b0;
    end
  end

  // Saturating count of consecutive refused ALU cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_r <= 4'd0;
    end else if (run && alu_valid && !alu_ready_s) begin
      starve_cnt_r <= (starve_cnt_r == 4'd15) ? starve_cnt_r : starve_cnt_r + 4'd1;
    end else begin
      starve_cnt_r <= 4'd0;
    end
  end

  assign alu_ready = alu_ready_s;
  assign mem_ready = mem_ready_s;
endmodule

// File: rtl/regfile_wb_sched.sv
// Register-file write-port scheduler: clears R1..R31 after reset, then
// forwards one ALU or MEM writeback per cycle onto registered D_En/D_Addr/D.
module regfile_wb_sched
  import regfile_pkg::*;
#(
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter int unsigned STARVE_LIMIT   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              D_En,
  output logic [ADDR_W-1:0] D_Addr,
  output logic [DATA_W-1:0] D,
  output logic              init_done
);
  localparam state_e RST_STATE = CLEAR_ON_RESET ? STATE_INIT : STATE_RUN;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(REG_COUNT - 1);

  state_e            state_r, state_next_s;
  logic [ADDR_W-1:0] clr_cnt_r;
  logic              d_en_r, init_done_r;
  logic [ADDR_W-1:0] d_addr_r;
  logic [DATA_W-1:0] d_r;
  logic              run_s, alu_ready_s, mem_ready_s, alu_hs_s, mem_hs_s;
  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [DATA_W-1:0] wr_data_s;

  assign run_s = (state_r == STATE_RUN);

  wb_prio_arb #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .run       (run_s),
    .alu_valid (alu_valid),
    .mem_valid (mem_valid),
    .alu_ready (alu_ready_s),
    .mem_ready (mem_ready_s)
  );

  assign alu_hs_s = alu_valid && alu_ready_s;
  assign mem_hs_s = mem_valid && mem_ready_s;

  // Next state and the write to register; R0 writes are consumed but dropped.
  always_comb begin
    state_next_s = state_r;
    wr_en_s      = 1'b0;
    wr_addr_s    = d_addr_r;
    wr_data_s    = d_r;
    case (state_r)
      STATE_INIT: begin
        wr_en_s   = 1'b1;
        wr_addr_s = clr_cnt_r;
        wr_data_s = 32'd0;
        if (clr_cnt_r == LAST_ADDR) begin
          state_next_s = STATE_RUN;
        end else begin
          state_next_s = STATE_INIT;
        end
      end
      STATE_RUN: begin
        if (alu_hs_s && (alu_addr != R0_ADDR)) begin
          wr_en_s   = 1'b1;
          wr_addr_s = alu_addr;
          wr_data_s = alu_data;
        end else if (!alu_hs_s && mem_hs_s && (mem_addr != R0_ADDR)) begin
          wr_en_s   = 1'b1;
          wr_addr_s = mem_addr;
          wr_data_s = mem_data;
        end else begin
          wr_en_s = 1'b0;
        end
      end
      default: begin
        state_next_s = RST_STATE;
      end
    endcase
  end

  // State, clear counter and registered write-port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= RST_STATE;
      clr_cnt_r   <= 5'd1;
      d_en_r      <= 1'b0;
      d_addr_r    <= 5'd0;
      d_r         <= 32'd0;
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      clr_cnt_r   <= (state_r == STATE_INIT) ? clr_cnt_r + 5'd1 : clr_cnt_r;
      d_en_r      <= wr_en_s;
      d_addr_r    <= wr_addr_s;
      d_r         <= wr_data_s;
      init_done_r <= run_s;
    end
  end

  assign alu_ready = alu_ready_s;
  assign mem_ready = mem_ready_s;
  assign D_En      = d_en_r;
  assign D_Addr    = d_addr_r;
  assign D         = d_r;
  assign init_done = init_done_r;
endmodule
